// File: rtl/interp_sequencer.sv
// rtl/interp_sequencer.sv - row sequencer for a two-pass (horizontal then vertical) interpolation FIR
// Optional stall counter enabled by defining INTERP_SEQ_STALL_CNT_EN.
module interp_sequencer #(
  parameter int BLK_ROWS = 8,
  parameter int TAPS     = 8,
  parameter int NUM_BLK  = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        load_in,
  output logic        load_L,
  output logic [1:0]  sel_phase,
  output logic        first_round,
  output logic [7:0]  row_cnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] stall_cnt
);

  localparam logic [7:0] C_ROWS_FIRST = 8'(BLK_ROWS + TAPS - 1);
  localparam logic [7:0] C_ROWS       = 8'(BLK_ROWS);
  localparam logic [7:0] C_LAT        = 8'(PIPE_LAT);
  localparam logic [7:0] C_LAST_BLK   = 8'(NUM_BLK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HORIZ, S_VERT, S_DRAIN, S_OUTPUT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_row_cnt, w_row_nxt;
  logic [7:0]  r_blk_cnt, w_blk_nxt;
  logic [7:0]  w_fetch_rows;
  logic        r_first_round, w_first_nxt;
  logic        w_done_nxt;
  logic [1:0]  r_sel_phase, w_sel_nxt;
  logic        r_load_L, r_out_valid, r_busy, r_done;

  // The first block of a column also fetches the filter's vertical apron.
  assign w_fetch_rows = r_first_round ? C_ROWS_FIRST : C_ROWS;

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_cnt;
    w_blk_nxt   = r_blk_cnt;
    w_first_nxt = r_first_round;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FILL;
          w_row_nxt   = 8'd0;
          w_blk_nxt   = 8'd0;
          w_first_nxt = 1'b1;
        end
      end
      S_FILL: begin
        if (in_valid) begin
          if (r_row_cnt == w_fetch_rows - 8'd1) begin
            w_state_nxt = S_HORIZ;
            w_row_nxt   = 8'd0;
          end else begin
            w_row_nxt = r_row_cnt + 8'd1;
          end
        end
      end
      S_HORIZ: begin
        if (r_row_cnt == w_fetch_rows - 8'd1) begin
          w_state_nxt = S_VERT;
          w_row_nxt   = 8'd0;
        end else begin
          w_row_nxt = r_row_cnt + 8'd1;
        end
      end
      S_VERT: begin
        if (r_row_cnt == C_ROWS - 8'd1) begin
          w_state_nxt = S_DRAIN;
          w_row_nxt   = 8'd0;
        end else begin
          w_row_nxt = r_row_cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        if (r_row_cnt == C_LAT - 8'd1) begin
          w_state_nxt = S_OUTPUT;
          w_row_nxt   = 8'd0;
        end else begin
          w_row_nxt = r_row_cnt + 8'd1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (r_row_cnt == C_ROWS - 8'd1) begin
            w_row_nxt   = 8'd0;
            w_first_nxt = 1'b0;
            if (r_blk_cnt == C_LAST_BLK) begin
              w_state_nxt = S_IDLE;
              w_blk_nxt   = 8'd0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_FILL;
              w_blk_nxt   = r_blk_cnt + 8'd1;
            end
          end else begin
            w_row_nxt = r_row_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = 8'd0;
      w_blk_nxt   = 8'd0;
      w_first_nxt = 1'b0;
      w_done_nxt  = 1'b0;
    end
    case (w_state_nxt)
      S_HORIZ: w_sel_nxt = 2'b01;
      S_VERT:  w_sel_nxt = 2'b10;
      default: w_sel_nxt = 2'b00;
    endcase
  end

  // Registered outputs are loaded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_row_cnt     <= 8'd0;
      r_blk_cnt     <= 8'd0;
      r_first_round <= 1'b0;
      r_sel_phase   <= 2'b00;
      r_load_L      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row_cnt     <= w_row_nxt;
      r_blk_cnt     <= w_blk_nxt;
      r_first_round <= w_first_nxt;
      r_sel_phase   <= w_sel_nxt;
      r_load_L      <= (w_state_nxt == S_HORIZ);
      r_out_valid   <= (w_state_nxt == S_OUTPUT);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
    end
  end

  assign in_ready    = (r_state == S_FILL);
  assign load_in     = in_ready & in_valid;
  assign load_L      = r_load_L;
  assign sel_phase   = r_sel_phase;
  assign first_round = r_first_round;
  assign row_cnt     = r_row_cnt;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;

`ifdef INTERP_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall_evt;

  assign w_stall_evt = ((r_state == S_FILL) && !in_valid) ||
                       ((r_state == S_OUTPUT) && !out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'd0;
    end else if (flush || ((r_state == S_IDLE) && start)) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/interp_sequencer.md
INTERP_SEQUENCER -- requirements
Module: interp_sequencer

Interface
REQ-001 SHALL have parameter BLK_ROWS, default 8, output rows per block.
REQ-002 SHALL have parameter TAPS, default 8, filter taps; first block fetches BLK_ROWS+TAPS-1 rows.
REQ-003 SHALL have parameter NUM_BLK, default 4, vertically stacked blocks per frame column.
REQ-004 SHALL have parameter PIPE_LAT, default 2, FIR pipeline latency in cycles.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle request to process a frame column.
REQ-008 flush  in  1  synchronous abort to IDLE.
REQ-009 in_valid  in  1  source has an input row.
REQ-010 in_ready  out  1  sequencer accepts a row this cycle.
REQ-011 load_in  out  1  shift-enable to the input row buffer.
REQ-012 load_L  out  1  capture-enable to the half-pixel shift register.
REQ-013 sel_phase  out  2  filter phase: 00 idle, 01 horizontal, 10 vertical.
REQ-014 first_round  out  1  current block is the first of the frame column.
REQ-015 row_cnt  out  8  row index within the current state.
REQ-016 out_valid  out  1  output row available; out_ready  in  1  sink accepts it.
REQ-017 busy  out  1  not IDLE; done  out  1  one-cycle frame-column completion pulse.
REQ-018 stall_cnt  out  16  stall counter (see Configuration).

Function
REQ-019 States SHALL be IDLE, FILL, HORIZ, VERT, DRAIN, OUTPUT.
REQ-020 IDLE: start -> FILL, first_round=1, blk_cnt=0, row_cnt=0; start SHALL be ignored in any other state.
REQ-021 FILL: in_ready=1; load_in = in_valid & in_ready, same cycle; row_cnt increments per accepted row.
REQ-022 FILL SHALL need BLK_ROWS+TAPS-1 rows if first_round, else BLK_ROWS; last accepted row -> HORIZ, row_cnt=0.
REQ-023 in_valid outside FILL SHALL be ignored; in_ready and load_in SHALL be 0 there.
REQ-024 HORIZ: sel_phase=01, load_L=1, for (first_round ? BLK_ROWS+TAPS-1 : BLK_ROWS) cycles -> VERT.
REQ-025 VERT: sel_phase=10, load_L=0, for BLK_ROWS cycles -> DRAIN.
REQ-026 DRAIN: sel_phase=00, for PIPE_LAT cycles -> OUTPUT, row_cnt=0.
REQ-027 OUTPUT: out_valid=1; row_cnt increments on out_valid & out_ready; out_ready=0 SHALL hold all state.
REQ-028 Last output row accepted: if blk_cnt==NUM_BLK-1 -> IDLE with done=1 for one cycle, else blk_cnt++, first_round=0, -> FILL.
REQ-029 busy SHALL be 1 in every state but IDLE.
REQ-030 flush SHALL take priority over all transitions: next cycle IDLE, all outputs at reset values, no done pulse.
REQ-031 row_cnt SHALL be 8 bits; BLK_ROWS+TAPS-1 <= 255 required.
REQ-032 Every output SHALL be registered except in_ready and load_in, which are combinational from state and in_valid.

Reset
REQ-033 rst low SHALL immediately force IDLE, in_ready=0, load_in=0, load_L=0, sel_phase=00, first_round=0, row_cnt=0, out_valid=0, busy=0, done=0, stall_cnt=0.
REQ-034 rst asserted mid-operation SHALL discard the block in progress; rst deassertion SHALL take effect on the next clk edge.

Configuration
REQ-035 Macro INTERP_SEQ_STALL_CNT_EN defined: stall_cnt counts cycles in FILL with in_valid=0 plus cycles in OUTPUT with out_ready=0; saturates at 16'hFFFF; cleared on start accepted from IDLE.
REQ-036 Macro undefined: stall_cnt SHALL be constant 0, no counter logic; all other behaviour unchanged.

Verification
REQ-037 Defaults, start, in_valid=1 continuous, out_ready=1: 15 load_in pulses, HORIZ 15 cycles, VERT 8, DRAIN 2, 8 out_valid rows, then FILL of 8 rows with first_round=0.
REQ-038 Four blocks back-to-back: exactly one done pulse, after the 32nd accepted output row; busy falls the same cycle.
REQ-039 in_valid toggled 1/0 during FILL: load_in only on in_valid=1 cycles, row_cnt stops at 14 then HORIZ.
REQ-040 out_ready=0 for 5 cycles at output row 3: out_valid held, row_cnt stays 3, stall_cnt +5 with macro, 0 without.
REQ-041 flush in VERT, and rst low in OUTPUT: IDLE next cycle / immediately, all outputs at reset values, no done.
REQ-042 start pulsed during HORIZ: ignored, sequence and counts identical to REQ-037.
